// File: rtl/code_loader_pkg.sv
// Shared state encoding, framing constants and length check for the UART boot loader.
package code_loader_pkg;

  typedef enum logic [2:0] {
    StSync,
    StLenLo,
    StLenHi,
    StData,
    StCsum,
    StResp,
    StRun
  } state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] ACK_BYTE  = 8'h06;
  localparam logic [7:0] NAK_BYTE  = 8'h15;

  // A frame is loadable when it carries at least one byte and fits the code memory.
  function automatic logic len_in_range(input logic [15:0] len, input int unsigned addr_w);
    return (len != 16'd0) && (32'(len) <= (32'd1 << addr_w));
  endfunction

endpackage

// File: rtl/code_loader_timeout.sv
// Inter-byte timeout: reloads on restart or while disabled, strobes expired when it runs out.
module code_loader_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_restart,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] LoadVal = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_restart || !i_enable) begin
      cnt_d = LoadVal;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  // A byte arriving in the expiry cycle wins over the timeout.
  assign o_expired = i_enable && !i_restart && (cnt_q == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= LoadVal;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/code_loader.sv
// UART boot loader for the ice51 core: frames bytes into code memory, replies ACK/NAK and
// owns the code port until an image is accepted. Checksum byte enabled by CODE_LOADER_CSUM_EN.
module code_loader
  import code_loader_pkg::*;
#(
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rx_valid,
  input  logic [DATA_W-1:0] i_rx_data,
  output logic              o_tx_valid,
  output logic [DATA_W-1:0] o_tx_data,
  input  logic              i_tx_ready,
  input  logic              i_cpu_wr,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_data,
  output logic              o_code_wr,
  output logic [ADDR_W-1:0] o_code_addr,
  output logic [DATA_W-1:0] o_code_data,
  output logic              o_cpu_hold,
  output logic              o_err
);

  localparam int unsigned AddrCntW = ADDR_W + 1;

  state_e              state_q, state_d;
  logic [7:0]          len_lo_q, len_lo_d;
  logic [15:0]         len_q, len_d;
  logic [AddrCntW-1:0] addr_q, addr_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                tx_valid_q, tx_valid_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                err_q, err_d;
`ifdef CODE_LOADER_CSUM_EN
  logic [DATA_W-1:0]   sum_q, sum_d;
`endif

  logic              resp_go;
  logic [DATA_W-1:0] resp_byte;
  logic              to_enable, to_expired, last_byte;
  logic [15:0]       len_rx;

  assign to_enable = (state_q == StLenLo) || (state_q == StLenHi) ||
                     (state_q == StData)  || (state_q == StCsum);
  assign len_rx    = {i_rx_data[7:0], len_lo_q};
  assign last_byte = (32'(addr_q) + 32'd1) == 32'(len_q);

  code_loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_restart(i_rx_valid),
    .i_enable (to_enable),
    .o_expired(to_expired)
  );

  always_comb begin
    state_d    = state_q;
    len_lo_d   = len_lo_q;
    len_d      = len_q;
    addr_d     = addr_q;
    wr_d       = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    err_d      = err_q;
    resp_go    = 1'b0;
    resp_byte  = DATA_W'(NAK_BYTE);
`ifdef CODE_LOADER_CSUM_EN
    sum_d      = sum_q;
`endif
    case (state_q)
      StSync: begin
        if (i_rx_valid && (i_rx_data == DATA_W'(SYNC_BYTE))) begin
          state_d = StLenLo;
          err_d   = 1'b0;
`ifdef CODE_LOADER_CSUM_EN
          sum_d   = '0;
`endif
        end
      end
      StLenLo: begin
        if (to_expired) begin
          resp_go = 1'b1;
        end else if (i_rx_valid) begin
          len_lo_d = i_rx_data[7:0];
          state_d  = StLenHi;
        end
      end
      StLenHi: begin
        if (to_expired) begin
          resp_go = 1'b1;
        end else if (i_rx_valid) begin
          len_d  = len_rx;
          addr_d = '0;
          if (len_in_range(len_rx, ADDR_W)) begin
            state_d = StData;
          end else begin
            resp_go = 1'b1;
          end
        end
      end
      StData: begin
        if (to_expired) begin
          resp_go = 1'b1;
        end else if (i_rx_valid) begin
          wr_d      = 1'b1;
          wr_addr_d = addr_q[ADDR_W-1:0];
          wr_data_d = i_rx_data;
          addr_d    = addr_q + AddrCntW'(1);
`ifdef CODE_LOADER_CSUM_EN
          sum_d     = sum_q + i_rx_data;
          if (last_byte) state_d = StCsum;
`else
          if (last_byte) begin
            resp_go   = 1'b1;
            resp_byte = DATA_W'(ACK_BYTE);
          end
`endif
        end
      end
`ifdef CODE_LOADER_CSUM_EN
      StCsum: begin
        if (to_expired) begin
          resp_go = 1'b1;
        end else if (i_rx_valid) begin
          resp_go   = 1'b1;
          resp_byte = (i_rx_data == sum_q) ? DATA_W'(ACK_BYTE) : DATA_W'(NAK_BYTE);
        end
      end
`endif
      StResp: begin
        if (i_tx_ready) begin
          tx_valid_d = 1'b0;
          if (tx_data_q == DATA_W'(ACK_BYTE)) begin
            state_d = StRun;
          end else begin
            state_d = StSync;
            err_d   = 1'b1;
          end
        end
      end
      StRun: ;
      default: state_d = StSync;
    endcase
    if (resp_go) begin
      state_d    = StResp;
      tx_valid_d = 1'b1;
      tx_data_d  = resp_byte;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StSync;
      len_lo_q   <= '0;
      len_q      <= '0;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      err_q      <= 1'b0;
`ifdef CODE_LOADER_CSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_lo_q   <= len_lo_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      wr_q       <= wr_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      err_q      <= err_d;
`ifdef CODE_LOADER_CSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  // Once running, the core owns the code port combinationally.
  assign o_cpu_hold  = (state_q != StRun);
  assign o_code_wr   = o_cpu_hold ? wr_q      : i_cpu_wr;
  assign o_code_addr = o_cpu_hold ? wr_addr_q : i_cpu_addr;
  assign o_code_data = o_cpu_hold ? wr_data_q : i_cpu_data;
  assign o_tx_valid  = tx_valid_q;
  assign o_tx_data   = tx_data_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_code_loader.sv
// Randomized self-checking bench for code_loader against a frame-level reference model.
module tb_code_loader;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 8;
  localparam int unsigned TO = 50;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;
`ifdef CODE_LOADER_CSUM_EN
  localparam bit CsumEn = 1'b1;
`else
  localparam bit CsumEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_valid;
  logic [DW-1:0] rx_data;
  logic          tx_valid;
  logic [DW-1:0] tx_data;
  logic          tx_ready;
  logic          cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_data;
  logic          code_wr;
  logic [AW-1:0] code_addr;
  logic [DW-1:0] code_data;
  logic          cpu_hold;
  logic          err;

  int checks = 0;
  int failures = 0;

  int         log_addr[$];
  logic [7:0] log_data[$];

  code_loader #(
    .ADDR_W        (AW),
    .DATA_W        (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rx_valid (rx_valid),
    .i_rx_data  (rx_data),
    .o_tx_valid (tx_valid),
    .o_tx_data  (tx_data),
    .i_tx_ready (tx_ready),
    .i_cpu_wr   (cpu_wr),
    .i_cpu_addr (cpu_addr),
    .i_cpu_data (cpu_data),
    .o_code_wr  (code_wr),
    .o_code_addr(code_addr),
    .o_code_data(code_data),
    .o_cpu_hold (cpu_hold),
    .o_err      (err)
  );

  always #5 clk = ~clk;

  // Record every loader-driven memory write.
  always @(negedge clk) begin
    if (!rst && code_wr && cpu_hold) begin
      log_addr.push_back(int'(code_addr));
      log_data.push_back(code_data);
    end
  end

  // Reference: response byte a complete frame should earn.
  function automatic logic [7:0] model_resp(input int len, input logic [7:0] pl[$],
                                            input logic [7:0] csum);
    logic [7:0] s = 8'h00;
    if (len < 1 || len > (1 << AW)) return NAK;
    foreach (pl[i]) s = s + pl[i];
    if (CsumEn && s != csum) return NAK;
    return ACK;
  endfunction

  function automatic logic [7:0] sum8(input logic [7:0] pl[$]);
    logic [7:0] s = 8'h00;
    foreach (pl[i]) s = s + pl[i];
    return s;
  endfunction

  task automatic apply_reset();
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
    cpu_wr = 1'b0; cpu_addr = '0; cpu_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    log_addr.delete(); log_data.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = b;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(input logic [15:0] len, input logic [7:0] pl[$],
                            input logic [7:0] csum, input int gap_max);
    send_byte(8'hA5, $urandom_range(gap_max, 0));
    send_byte(len[7:0], $urandom_range(gap_max, 0));
    send_byte(len[15:8], $urandom_range(gap_max, 0));
    foreach (pl[i]) send_byte(pl[i], $urandom_range(gap_max, 0));
    if (CsumEn && pl.size() != 0) send_byte(csum, 0);
  endtask

  task automatic wait_tx(input int budget, output bit seen, output int cycles);
    seen = 1'b0;
    cycles = 0;
    while (cycles < budget) begin
      if (tx_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic accept_tx();
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (cpu_hold !== 1'b1) begin failures++; $display("FAIL reset_hold got=%b want=1", cpu_hold); end
    checks++; if (code_wr !== 1'b0) begin failures++; $display("FAIL reset_code_wr got=%b want=0", code_wr); end
    checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
      failures++; $display("FAIL reset_tx got=%b/%h want=0/00", tx_valid, tx_data);
    end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", err); end
  endtask

  task automatic test_basic_load();
    logic [7:0] pl[$] = '{8'h11, 8'h22, 8'h33, 8'h44};
    bit seen; int cyc; int bad = 0;
    apply_reset();
    send_frame(16'd4, pl, 8'hAA, 2);
    wait_tx(20, seen, cyc);
    checks++; if (!seen || tx_data !== model_resp(4, pl, 8'hAA)) begin
      failures++; $display("FAIL basic_resp seen=%b got=%h want=%h", seen, tx_data, ACK);
    end
    checks++; if (cpu_hold !== 1'b1) begin failures++; $display("FAIL basic_hold_pre got=%b want=1", cpu_hold); end
    accept_tx();
    checks++; if (cpu_hold !== 1'b0) begin failures++; $display("FAIL basic_hold_post got=%b want=0", cpu_hold); end
    checks++; if (log_addr.size() != 4) begin failures++; $display("FAIL basic_wr_count got=%0d want=4", log_addr.size()); end
    else foreach (pl[i]) if (log_addr[i] != i || log_data[i] !== pl[i]) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL basic_wr_content got=%0d bad want=0", bad); end
  endtask

  task automatic test_bad_len();
    logic [15:0] lens[2] = '{16'h0000, 16'h0401};
    logic [7:0] none[$];
    bit seen; int cyc;
    foreach (lens[k]) begin
      apply_reset();
      send_frame(lens[k], none, 8'h00, 1);
      wait_tx(20, seen, cyc);
      checks++; if (!seen || tx_data !== model_resp(int'(lens[k]), none, 8'h00)) begin
        failures++; $display("FAIL badlen_resp len=%h seen=%b got=%h want=%h", lens[k], seen, tx_data, NAK);
      end
      accept_tx();
      checks++; if (err !== 1'b1 || cpu_hold !== 1'b1) begin
        failures++; $display("FAIL badlen_err len=%h got err=%b hold=%b want 1/1", lens[k], err, cpu_hold);
      end
      checks++; if (log_addr.size() != 0) begin
        failures++; $display("FAIL badlen_no_wr len=%h got=%0d want=0", lens[k], log_addr.size());
      end
      send_byte(8'hA5, 0);
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL badlen_err_clear got=%b want=0", err); end
    end
  endtask

  task automatic test_csum_bad();
`ifdef CODE_LOADER_CSUM_EN
    logic [7:0] pl[$] = '{8'h01, 8'h02};
    logic [7:0] one[$];
    bit seen; int cyc;
    apply_reset();
    send_frame(16'd2, pl, 8'h04, 1);
    wait_tx(20, seen, cyc);
    checks++; if (!seen || tx_data !== model_resp(2, pl, 8'h04)) begin
      failures++; $display("FAIL csum_resp seen=%b got=%h want=%h", seen, tx_data, NAK);
    end
    accept_tx();
    checks++; if (cpu_hold !== 1'b1 || err !== 1'b1 || log_addr.size() != 2) begin
      failures++; $display("FAIL csum_after got hold=%b err=%b wr=%0d want 1/1/2", cpu_hold, err, log_addr.size());
    end
    one.push_back(8'($urandom));
    send_frame(16'd1, one, sum8(one), 1);
    wait_tx(20, seen, cyc);
    checks++; if (!seen || tx_data !== ACK) begin
      failures++; $display("FAIL csum_resync seen=%b got=%h want=%h", seen, tx_data, ACK);
    end
    accept_tx();
`endif
  endtask

  task automatic test_timeout();
    logic [7:0] d0, d1, v0, d0s;
    bit seen; int cyc; bit stable = 1'b1;
    apply_reset();
    d0 = 8'($urandom); d1 = 8'($urandom);
    send_byte(8'hA5, 0); send_byte(8'h03, 0); send_byte(8'h00, 0);
    send_byte(d0, 0); send_byte(d1, 0);
    wait_tx(2 * TO, seen, cyc);
    checks++; if (!seen) begin failures++; $display("FAIL timeout_seen got=0 want=1 after %0d", cyc); end
    checks++; if (cyc < TO - 5) begin failures++; $display("FAIL timeout_early got=%0d want>=%0d", cyc, TO - 5); end
    checks++; if (tx_data !== NAK) begin failures++; $display("FAIL timeout_resp got=%h want=%h", tx_data, NAK); end
    v0 = {7'd0, tx_valid}; d0s = tx_data;
    repeat (10) begin
      @(negedge clk);
      if ({7'd0, tx_valid} !== v0 || tx_data !== d0s) stable = 1'b0;
    end
    checks++; if (!stable || v0 !== 8'd1) begin failures++; $display("FAIL timeout_hold_stable got=%b want=1", stable); end
    accept_tx();
    checks++; if (err !== 1'b1 || cpu_hold !== 1'b1 || log_addr.size() != 2 || log_data[1] !== d1) begin
      failures++; $display("FAIL timeout_after got err=%b hold=%b wr=%0d want 1/1/2", err, cpu_hold, log_addr.size());
    end
  endtask

  task automatic test_full_image();
    logic [7:0] pl[$];
    bit seen; int cyc; int bad = 0;
    apply_reset();
    for (int i = 0; i < (1 << AW); i++) pl.push_back(8'($urandom));
    send_frame(16'(1 << AW), pl, sum8(pl), 0);
    wait_tx(20, seen, cyc);
    checks++; if (!seen || tx_data !== model_resp(1 << AW, pl, sum8(pl))) begin
      failures++; $display("FAIL full_resp seen=%b got=%h want=%h", seen, tx_data, ACK);
    end
    accept_tx();
    checks++; if (log_addr.size() != (1 << AW)) begin
      failures++; $display("FAIL full_wr_count got=%0d want=%0d", log_addr.size(), 1 << AW);
    end else begin
      foreach (pl[i]) if (log_addr[i] != i || log_data[i] !== pl[i]) bad++;
      checks++; if (log_addr[(1 << AW) - 1] != 32'h3FF) begin
        failures++; $display("FAIL full_last_addr got=%h want=3ff", log_addr[(1 << AW) - 1]);
      end
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL full_wr_content got=%0d bad want=0", bad); end
  endtask

  task automatic test_random_frames();
    for (int it = 0; it < 4; it++) begin
      logic [7:0] pl[$];
      logic [7:0] cs, want;
      int len; int bad = 0; bit seen; int cyc;
      apply_reset();
      len = $urandom_range(40, 1);
      for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
      cs = sum8(pl);
      if (CsumEn && ($urandom_range(1, 0) == 1)) cs = cs ^ 8'($urandom_range(255, 1));
      want = model_resp(len, pl, cs);
      send_frame(16'(len), pl, cs, 3);
      wait_tx(20, seen, cyc);
      checks++; if (!seen || tx_data !== want) begin
        failures++; $display("FAIL rand_resp it=%0d seen=%b got=%h want=%h", it, seen, tx_data, want);
      end
      accept_tx();
      checks++; if (cpu_hold !== (want == NAK)) begin
        failures++; $display("FAIL rand_hold it=%0d got=%b want=%b", it, cpu_hold, want == NAK);
      end
      if (log_addr.size() != len) bad = 1000;
      else foreach (pl[i]) if (log_addr[i] != i || log_data[i] !== pl[i]) bad++;
      checks++; if (bad != 0) begin failures++; $display("FAIL rand_writes it=%0d got=%0d bad want=0", it, bad); end
    end
  endtask

  task automatic test_rst_and_run();
    logic [7:0] one[$];
    bit seen; int cyc; int bad = 0; bit quiet = 1'b1;
    apply_reset();
    send_byte(8'hA5, 0); send_byte(8'h05, 0); send_byte(8'h00, 0);
    send_byte(8'h5A, 0); send_byte(8'hC3, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++; if (cpu_hold !== 1'b1 || tx_valid !== 1'b0 || err !== 1'b0 || code_wr !== 1'b0) begin
      failures++; $display("FAIL midrst_state got hold=%b tx=%b err=%b wr=%b want 1/0/0/0",
                           cpu_hold, tx_valid, err, code_wr);
    end
    log_addr.delete(); log_data.delete();
    one.push_back(8'($urandom));
    send_frame(16'd1, one, sum8(one), 1);
    wait_tx(20, seen, cyc);
    checks++; if (!seen || tx_data !== ACK) begin
      failures++; $display("FAIL reload_resp seen=%b got=%h want=%h", seen, tx_data, ACK);
    end
    accept_tx();
    checks++; if (log_addr.size() != 1 || log_addr[0] != 0 || log_data[0] !== one[0] || cpu_hold !== 1'b0) begin
      failures++; $display("FAIL reload_write got wr=%0d hold=%b want 1/0", log_addr.size(), cpu_hold);
    end
    for (int i = 0; i < 6; i++) begin
      logic          w = 1'($urandom);
      logic [AW-1:0] a = AW'($urandom);
      logic [DW-1:0] d = DW'($urandom);
      cpu_wr = w; cpu_addr = a; cpu_data = d;
      #1;
      if (code_wr !== w || code_addr !== a || code_data !== d) bad++;
      @(negedge clk);
    end
    cpu_wr = 1'b0;
    checks++; if (bad != 0) begin failures++; $display("FAIL run_passthru got=%0d bad want=0", bad); end
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
    repeat (5) begin
      @(negedge clk);
      if (tx_valid !== 1'b0 || cpu_hold !== 1'b0) quiet = 1'b0;
    end
    checks++; if (!quiet) begin failures++; $display("FAIL run_ignores_rx got=0 want=1"); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_load();
    test_bad_len();
    test_csum_bad();
    test_timeout();
    test_full_image();
    test_random_frames();
    test_rst_and_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
